filter_delay_line: RTL
======================

# filter_delay_line

Parametrised tapped delay line for the filter datapath, replacing single-stage sample registers with one block that holds the last N samples of a W-bit stream. Samples shift in only on a sample strobe, every tap is visible in parallel for the multiply-accumulate stage, and a fill counter tells downstream logic when the window holds N real samples. It sits between the sample source (ADC/decimator) and the FIR coefficient multipliers.

## Interface

- W, 25, sample width in bits (25 matches the existing filter sample format)
- N, 4, number of taps (depth); legal range 2..64
- FW, $clog2(N+1), width of the fill counter (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- en  in  1  sample strobe; when 1 at a clock edge, data_i is shifted in
- clr  in  1  synchronous clear of all taps and the fill count
- data_i  in  W  incoming sample
- taps_o  out  W*N  all taps flattened; tap k at bits [k*W +: W], tap 0 = newest
- data_o  out  W  oldest tap (tap N-1), the N-sample-delayed output
- fill_o  out  FW  number of valid samples held, saturates at N
- full_o  out  1  1 when fill_o == N
- strobe_o  out  1  registered copy of the accepted en; pulses in the cycle the new taps are visible

## Operation

- Reset (rst = 0, asynchronous): all taps = 0, fill_o = 0, full_o = 0, strobe_o = 0; held while rst = 0.
- Priority at each rising edge with rst = 1: clr > en > hold.
- clr = 1: all taps = 0, fill_o = 0, strobe_o = 0; a simultaneous en is dropped (sample lost, no shift).
- en = 1, clr = 0: tap0 <= data_i; tap k <= tap k-1 for k = 1..N-1; old tap N-1 discarded; fill_o <= min(fill_o + 1, N); strobe_o <= 1.
- en = 0, clr = 0: taps and fill_o hold; strobe_o <= 0.
- fill_o saturates at N; no wrap to 0 under a continuous en stream.
- full_o is combinational from fill_o (no extra latency).
- data_o is a direct alias of tap N-1; taps_o is the concatenation of tap registers; no combinational path from data_i to any output.
- Taps are treated as raw bit vectors; no sign extension, rounding or arithmetic is applied.
- en held high continuously: one shift per clock, strobe_o stays 1.

## Timing

- Latency data_i -> tap0: 1 clock after the edge that samples en = 1.
- Latency data_i -> data_o: N accepted strobes (N clocks if en is held high).
- strobe_o asserts in the same cycle the updated taps and fill_o appear; the MAC stage samples taps_o when strobe_o = 1.
- rst asserted mid-stream: outputs go to reset values immediately (without waiting for clk); first shift after release happens on the first edge with rst = 1 and en = 1.
- clr takes effect on the edge at which it is sampled; outputs read 0 in the following cycle.

## Test plan

- Reset: drive rst = 0 with taps previously loaded -> taps_o = 0, data_o = 0, fill_o = 0, full_o = 0, strobe_o = 0 before the next clk edge.
- Fill: N = 4, en = 1 for 4 clocks with data_i = 1,2,3,4 -> taps (tap0..tap3) = 4,3,2,1; data_o = 1; fill_o steps 1,2,3,4; full_o = 1 after the 4th edge; strobe_o = 1 each cycle.
- Gapped strobe: en pattern 1,0,0,1 with data_i = 0x1ABCDE, then 0x000055 -> taps shift only twice, tap0 = 0x000055, tap1 = 0x1ABCDE, fill_o = 2, strobe_o = 1,0,0,1.
- Saturation/overflow: N = 4, 10 consecutive strobes with data_i = 1..10 -> taps = 10,9,8,7, data_o = 7, fill_o stays 4 (no wrap).
- clr vs en: full line, assert clr = 1 and en = 1 on the same edge with data_i = 0x00FFFF -> all taps 0, fill_o = 0, full_o = 0, strobe_o = 0; next strobe with 0x000003 gives tap0 = 3, fill_o = 1.
- Parameter sweep: W = 8, N = 2 and W = 25, N = 16 -> same fill/shift behaviour; fill_o width 2 and 5 bits respectively, full_o at fill_o = 2 and 16.

Source files
------------

// File: rtl/filter_delay_line.sv
// Tapped delay line holding the last N samples of a W-bit stream.
// Shifts only on the sample strobe and reports how many taps hold real data.
module filter_delay_line #(
    parameter  int W  = 25,
    parameter  int N  = 4,
    localparam int FW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           clr,
    input  logic [W-1:0]   data_i,
    output logic [W*N-1:0] taps_o,
    output logic [W-1:0]   data_o,
    output logic [FW-1:0]  fill_o,
    output logic           full_o,
    output logic           strobe_o
);

    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [W-1:0]  tap_q [N];
    logic [W-1:0]  tap_d [N];
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic          strobe_q;
    logic          strobe_d;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            tap_d[k] = tap_q[k];
        end
        fill_d   = fill_q;
        strobe_d = 1'b0;
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                tap_d[k] = '0;
            end
            fill_d = '0;
        end else if (en) begin
            tap_d[0] = data_i;
            for (int k = 1; k < N; k++) begin
                tap_d[k] = tap_q[k-1];
            end
            // Saturate so a continuous stream never wraps the count
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                tap_q[k] <= '0;
            end
            fill_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                tap_q[k] <= tap_d[k];
            end
            fill_q   <= fill_d;
            strobe_q <= strobe_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_taps
        assign taps_o[g*W +: W] = tap_q[g];
    end

    assign data_o   = tap_q[N-1];
    assign fill_o   = fill_q;
    assign full_o   = (fill_q == FILL_MAX);
    assign strobe_o = strobe_q;

endmodule
